// File: rtl/splice_wr_arbiter_if.sv
// DDR write command/data port: the arbiter drives it as master, the DDR controller is the slave.
interface splice_wr_arbiter_if #(
  parameter int ADDR_W = 20
) ();
  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic [15:0]       wr_data;
  logic              wr_data_last;

  modport master (
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output wr_data_valid, wr_data, wr_data_last,
    input  wr_cmd_ready, wr_data_ready
  );

  modport slave (
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  wr_data_valid, wr_data, wr_data_last,
    output wr_cmd_ready, wr_data_ready
  );
endinterface

// File: rtl/splice_wr_arbiter.sv
// Round-robin DDR write scheduler tiling four video channels into a 2x2 mosaic; burst period >= BURST_LEN+3 cycles.
// Command and data valids hold until ready; FIFO pops only on accepted data beats.
module splice_wr_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int LINE_PIX  = 640,
  parameter int LINE_NUM  = 360,
  parameter int FRAME_W   = 1280,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk_ddr,
  input  logic        rst,
  input  logic [3:0]  ch_vs_pose,
  input  logic [39:0] ch_level,
  input  logic [63:0] ch_rd_data,
  output logic [3:0]  ch_rd_en,
  output logic [3:0]  ch_frame_done,
  output logic        busy,
  splice_wr_arbiter_if.master wr
);

  localparam int XW = $clog2(LINE_PIX + 1);
  localparam int YW = $clog2(LINE_NUM + 1);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIX - BURST_LEN);
  localparam logic [YW-1:0] Y_LAST = YW'(LINE_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_CMD, S_DATA, S_DONE} state_t;

  state_t            state, state_nx;
  logic [1:0]        grant, rr_ptr, pick;
  logic              pick_vld;
  logic [3:0]        elig;
  logic [ADDR_W-1:0] pick_addr, addr_q;
  logic [BW-1:0]     beat;
  logic              beat_last, pend;
  logic              line_end, frame_end, restart_g;

  logic [XW-1:0]     x_cnt    [4];
  logic [YW-1:0]     y_cnt    [4];
  logic [ADDR_W-1:0] row_base [4];
  logic [3:0]        done;

  // Quadrant origin: bit 1 selects the lower half, bit 0 the right half.
  function automatic logic [ADDR_W-1:0] quad_off(input logic [1:0] c);
    logic [ADDR_W-1:0] o;
    o = '0;
    if (c[1]) o = ADDR_W'(LINE_NUM * FRAME_W);
    if (c[0]) o = o + ADDR_W'(LINE_PIX);
    return o;
  endfunction

  always_comb begin
    elig = '0;
    for (int c = 0; c < 4; c++)
      elig[c] = (ch_level[c*10 +: 10] >= 10'(BURST_LEN)) && !done[c];
  end

  // Scan downwards so the channel closest to rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (elig[rr_ptr + 2'(k)]) begin
        pick_vld = 1'b1;
        pick     = rr_ptr + 2'(k);
      end
    end
  end

  // A frame start landing in the same ARB cycle must address the new frame's origin.
  always_comb begin
    pick_addr = ADDR_W'(BASE_ADDR) +
                (ch_vs_pose[pick] ? quad_off(pick) : row_base[pick] + ADDR_W'(x_cnt[pick]));
  end

  assign beat_last = (beat == BW'(BURST_LEN - 1));
  assign line_end  = (x_cnt[grant] == X_LAST);
  assign frame_end = line_end && (y_cnt[grant] == Y_LAST);
  assign restart_g = pend | ch_vs_pose[grant];

  always_ff @(posedge clk_ddr) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    wr.wr_cmd_valid   = 1'b0;
    wr.wr_cmd_addr    = '0;
    wr.wr_cmd_len     = '0;
    wr.wr_data_valid  = 1'b0;
    wr.wr_data        = '0;
    wr.wr_data_last   = 1'b0;
    ch_rd_en          = '0;
    ch_frame_done     = '0;
    busy              = 1'b0;
    case (state)
      S_IDLE: state_nx = S_ARB;
      S_ARB: begin
        if (pick_vld) state_nx = S_CMD;
      end
      S_CMD: begin
        busy            = 1'b1;
        wr.wr_cmd_valid = 1'b1;
        wr.wr_cmd_addr  = addr_q;
        wr.wr_cmd_len   = 8'(BURST_LEN);
        if (wr.wr_cmd_ready) state_nx = S_DATA;
      end
      S_DATA: begin
        busy             = 1'b1;
        wr.wr_data_valid = 1'b1;
        wr.wr_data       = ch_rd_data[{grant, 4'b0000} +: 16];
        wr.wr_data_last  = beat_last;
        if (wr.wr_data_ready) begin
          ch_rd_en[grant] = 1'b1;
          if (beat_last) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        state_nx = S_ARB;
        if (!restart_g && frame_end) ch_frame_done[grant] = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ddr) begin
    if (!rst) begin
      grant  <= '0;
      rr_ptr <= '0;
      addr_q <= '0;
      beat   <= '0;
      pend   <= 1'b0;
    end else begin
      case (state)
        S_ARB: begin
          if (pick_vld) begin
            grant  <= pick;
            rr_ptr <= pick + 2'd1;
            addr_q <= pick_addr;
            pend   <= 1'b0;
          end
        end
        S_CMD: begin
          beat <= '0;
          if (ch_vs_pose[grant]) pend <= 1'b1;
        end
        S_DATA: begin
          if (wr.wr_data_ready) beat <= beat + BW'(1);
          if (ch_vs_pose[grant]) pend <= 1'b1;
        end
        S_DONE: pend <= 1'b0;
        default: ;
      endcase
    end
  end

  // The granted channel defers its frame restart to DONE so an issued burst keeps its address.
  always_ff @(posedge clk_ddr) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        x_cnt[c]    <= '0;
        y_cnt[c]    <= '0;
        row_base[c] <= quad_off(2'(c));
      end
      done <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (ch_vs_pose[c] && !(busy && grant == 2'(c))) begin
          x_cnt[c]    <= '0;
          y_cnt[c]    <= '0;
          row_base[c] <= quad_off(2'(c));
          done[c]     <= 1'b0;
        end else if (state == S_DONE && grant == 2'(c)) begin
          if (restart_g) begin
            x_cnt[c]    <= '0;
            y_cnt[c]    <= '0;
            row_base[c] <= quad_off(2'(c));
            done[c]     <= 1'b0;
          end else if (line_end) begin
            x_cnt[c]    <= '0;
            y_cnt[c]    <= y_cnt[c] + YW'(1);
            row_base[c] <= row_base[c] + ADDR_W'(FRAME_W);
            if (frame_end) done[c] <= 1'b1;
          end else begin
            x_cnt[c] <= x_cnt[c] + XW'(BURST_LEN);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_splice_wr_arbiter.sv
// Bench for splice_wr_arbiter on a reduced mosaic (64x4 quadrants, stride 128) with a transaction-level model.
module tb_splice_wr_arbiter;
  localparam int BL = 16, LP = 64, LN = 4, FW = 128, AW = 20, BASE = 0;
  localparam int PH_IDLE = 0, PH_ARB = 1, PH_CMD = 2, PH_DATA = 3, PH_DONE = 4;

  logic        clk_ddr = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ch_vs_pose = '0;
  logic [39:0] ch_level = '0;
  logic [63:0] ch_rd_data;
  logic [3:0]  ch_rd_en, ch_frame_done;
  logic        busy;

  splice_wr_arbiter_if #(.ADDR_W(AW)) wr ();

  splice_wr_arbiter #(
    .BURST_LEN(BL), .LINE_PIX(LP), .LINE_NUM(LN), .FRAME_W(FW), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk_ddr(clk_ddr), .rst(rst), .ch_vs_pose(ch_vs_pose), .ch_level(ch_level),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en), .ch_frame_done(ch_frame_done),
    .busy(busy), .wr(wr)
  );

  always #5 clk_ddr = ~clk_ddr;

  int errors = 0, checks = 0;

  // Show-ahead FIFO heads: {channel, sequence number}.
  logic [13:0] env_seq [4] = '{default: 14'd0};
  assign ch_rd_data = {2'd3, env_seq[3], 2'd2, env_seq[2], 2'd1, env_seq[1], 2'd0, env_seq[0]};

  logic [AW-1:0] acc[$];
  int pop_cnt [4] = '{default: 0};
  int fd_cnt  [4] = '{default: 0};

  // Reference model
  int          m_ph = PH_IDLE, m_rr = 0, m_g = 0, m_beat = 0;
  logic [AW-1:0] m_addr = '0;
  bit          m_pend = 1'b0;
  int          m_x [4] = '{default: 0};
  int          m_y [4] = '{default: 0};
  bit          m_done [4] = '{default: 1'b0};
  logic [13:0] m_seq [4] = '{default: 14'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qoff(input int c);
    return ((c >= 2) ? LN * FW : 0) + ((c % 2 == 1) ? LP : 0);
  endfunction

  always @(negedge clk_ddr) begin : cmp
    bit e_cv, e_dv, e_last, e_busy, found, in_burst;
    logic [AW-1:0] e_addr;
    logic [7:0]  e_len;
    logic [15:0] e_dat;
    logic [3:0]  e_en, e_fd;
    int old_g, c;

    e_cv   = (m_ph == PH_CMD);
    e_addr = e_cv ? m_addr : '0;
    e_len  = e_cv ? 8'(BL) : 8'd0;
    e_dv   = (m_ph == PH_DATA);
    e_dat  = e_dv ? {2'(m_g), m_seq[m_g]} : 16'd0;
    e_last = e_dv && (m_beat == BL - 1);
    e_en   = (e_dv && wr.wr_data_ready) ? 4'(1 << m_g) : 4'd0;
    e_busy = (m_ph >= PH_CMD);
    e_fd   = 4'd0;
    if (m_ph == PH_DONE && !(m_pend || ch_vs_pose[m_g]) && m_x[m_g] + BL == LP && m_y[m_g] + 1 == LN)
      e_fd = 4'(1 << m_g);

    chk("cmd_valid", 32'(wr.wr_cmd_valid), 32'(e_cv));
    chk("cmd_addr", 32'(wr.wr_cmd_addr), 32'(e_addr));
    chk("cmd_len", 32'(wr.wr_cmd_len), 32'(e_len));
    chk("data_valid", 32'(wr.wr_data_valid), 32'(e_dv));
    chk("data", 32'(wr.wr_data), 32'(e_dat));
    chk("data_last", 32'(wr.wr_data_last), 32'(e_last));
    chk("rd_en", 32'(ch_rd_en), 32'(e_en));
    chk("frame_done", 32'(ch_frame_done), 32'(e_fd));
    chk("busy", 32'(busy), 32'(e_busy));

    if (wr.wr_cmd_valid && wr.wr_cmd_ready) acc.push_back(wr.wr_cmd_addr);
    for (int k = 0; k < 4; k++) begin
      if (ch_rd_en[k]) begin
        env_seq[k] = env_seq[k] + 14'd1;
        pop_cnt[k]++;
      end
      if (ch_frame_done[k]) fd_cnt[k]++;
    end

    // Advance the model across the coming edge; FIFO pops happen regardless of reset.
    if (m_ph == PH_DATA && wr.wr_data_ready) m_seq[m_g] = m_seq[m_g] + 14'd1;
    if (!rst) begin
      m_ph = PH_IDLE; m_rr = 0; m_g = 0; m_beat = 0; m_addr = '0; m_pend = 1'b0;
      for (int k = 0; k < 4; k++) begin m_x[k] = 0; m_y[k] = 0; m_done[k] = 1'b0; end
    end else begin
      in_burst = (m_ph >= PH_CMD);
      old_g = m_g;
      case (m_ph)
        PH_IDLE: m_ph = PH_ARB;
        PH_ARB: begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            c = (m_rr + k) % 4;
            if (!found && ch_level[c*10 +: 10] >= BL && !m_done[c]) begin
              found = 1'b1;
              m_g = c;
            end
          end
          if (found) begin
            m_addr = AW'(BASE + qoff(m_g) + (ch_vs_pose[m_g] ? 0 : m_y[m_g] * FW + m_x[m_g]));
            m_rr = (m_g + 1) % 4;
            m_pend = 1'b0;
            m_ph = PH_CMD;
          end
        end
        PH_CMD: begin
          if (ch_vs_pose[m_g]) m_pend = 1'b1;
          if (wr.wr_cmd_ready) begin m_ph = PH_DATA; m_beat = 0; end
        end
        PH_DATA: begin
          if (ch_vs_pose[m_g]) m_pend = 1'b1;
          if (wr.wr_data_ready) begin
            if (m_beat == BL - 1) m_ph = PH_DONE;
            else m_beat++;
          end
        end
        default: begin
          if (m_pend || ch_vs_pose[m_g]) begin
            m_x[m_g] = 0; m_y[m_g] = 0; m_done[m_g] = 1'b0;
          end else begin
            m_x[m_g] += BL;
            if (m_x[m_g] == LP) begin
              m_x[m_g] = 0;
              m_y[m_g]++;
              if (m_y[m_g] == LN) m_done[m_g] = 1'b1;
            end
          end
          m_pend = 1'b0;
          m_ph = PH_ARB;
        end
      endcase
      for (int k = 0; k < 4; k++)
        if (ch_vs_pose[k] && !(in_burst && k == old_g)) begin
          m_x[k] = 0; m_y[k] = 0; m_done[k] = 1'b0;
        end
    end
  end

  int rdy_mode = 0;  // 0 always ready, 1 random, 2 data toggling, 3 manual

  task automatic tick();
    @(posedge clk_ddr);
    #1;
    case (rdy_mode)
      0: begin wr.wr_cmd_ready = 1'b1; wr.wr_data_ready = 1'b1; end
      1: begin
        wr.wr_cmd_ready  = 1'($urandom_range(0, 1));
        wr.wr_data_ready = ($urandom_range(0, 3) != 0);
      end
      2: begin wr.wr_cmd_ready = 1'b1; wr.wr_data_ready = ~wr.wr_data_ready; end
      default: ;
    endcase
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i = 0;
    while (acc.size() < n && i < budget) begin tick(); i++; end
    chk("cmd_wait_timeout", 32'(acc.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ch_vs_pose = '0;
    tick(); tick();
    rst = 1'b1;
    acc.delete();
    for (int k = 0; k < 4; k++) begin pop_cnt[k] = 0; fd_cnt[k] = 0; end
  endtask

  int exp_rr [5];

  initial begin
    wr.wr_cmd_ready = 1'b0;
    wr.wr_data_ready = 1'b0;
    exp_rr = '{0, 64, 512, 576, 16};
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_valid", 32'(wr.wr_cmd_valid), 32'd0);
    chk("reset_rd_en", 32'(ch_rd_en), 32'd0);
    rst = 1'b1;

    // Single burst on ch0
    ch_level = 40'd16;
    wait_acc(1, 50);
    ch_level = '0;
    repeat (25) tick();
    chk("single_addr", 32'(acc[0]), 32'd0);
    chk("single_cmds", 32'(acc.size()), 32'd1);
    chk("single_pops", 32'(pop_cnt[0]), 32'd16);

    // Round robin from reset
    do_reset();
    ch_level = {4{10'd64}};
    wait_acc(5, 200);
    ch_level = '0;
    repeat (25) tick();
    for (int i = 0; i < 5; i++) chk("rr_addr", 32'(acc[i]), 32'(exp_rr[i]));

    // Line wrap and frame completion on ch0
    do_reset();
    ch_level = 40'd1023;
    wait_acc(16, 500);
    repeat (60) tick();
    chk("frame_cmds", 32'(acc.size()), 32'd16);
    chk("wrap_addr4", 32'(acc[3]), 32'd48);
    chk("wrap_addr5", 32'(acc[4]), 32'd128);
    chk("last_addr", 32'(acc[15]), 32'd432);
    chk("frame_done_cnt", 32'(fd_cnt[0]), 32'd1);
    ch_vs_pose = 4'b0001;
    tick();
    ch_vs_pose = '0;
    wait_acc(17, 60);
    chk("restart_addr", 32'(acc[16]), 32'd0);
    ch_level = '0;
    repeat (25) tick();

    // Backpressure on command, toggling data ready
    do_reset();
    rdy_mode = 3;
    wr.wr_cmd_ready = 1'b0;
    wr.wr_data_ready = 1'b0;
    ch_level = {20'd0, 10'd16, 10'd0};
    for (int i = 0; i < 20 && !wr.wr_cmd_valid; i++) tick();
    repeat (5) tick();
    chk("bp_cmd_hold", 32'(wr.wr_cmd_valid), 32'd1);
    chk("bp_addr_hold", 32'(wr.wr_cmd_addr), 32'd64);
    rdy_mode = 2;
    wait_acc(1, 10);
    ch_level = '0;
    repeat (50) tick();
    chk("bp_pops", 32'(pop_cnt[1]), 32'd16);
    rdy_mode = 0;

    // Frame start during a ch0 burst, and on idle ch1
    do_reset();
    ch_level = {20'd0, 10'd1023, 10'd1023};
    wait_acc(11, 400);
    chk("vs_burst_addr", 32'(acc[10]), 32'd144);
    ch_vs_pose = 4'b0011;
    tick();
    ch_vs_pose = '0;
    wait_acc(13, 100);
    chk("vs_ch1_addr", 32'(acc[11]), 32'd64);
    chk("vs_ch0_addr", 32'(acc[12]), 32'd0);
    ch_level = '0;
    repeat (25) tick();

    // Reset in the middle of a data phase
    acc.delete();
    ch_level = {4{10'd64}};
    wait_acc(2, 80);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_data_valid", 32'(wr.wr_data_valid), 32'd0);
    chk("midrst_rd_en", 32'(ch_rd_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    acc.delete();
    wait_acc(1, 20);
    chk("midrst_first_addr", 32'(acc[0]), 32'd0);
    ch_level = '0;
    repeat (25) tick();

    // Randomized traffic
    rdy_mode = 1;
    for (int n = 0; n < 6000; n++) begin
      tick();
      if (n % 8 == 0)
        for (int k = 0; k < 4; k++) ch_level[k*10 +: 10] = 10'($urandom_range(0, 40));
      for (int k = 0; k < 4; k++) ch_vs_pose[k] = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 2999) != 0);
    end
    rst = 1'b1;
    ch_vs_pose = '0;
    rdy_mode = 0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/splice_wr_arbiter.md
# splice_wr_arbiter

Round-robin write scheduler that shares the single DDR write port among four RGB565 video input channels and tiles them into one 2x2 mosaic frame. It sits between the per-channel show-ahead input FIFOs, which are fed by the HDMI/camera input stages, and the DDR controller's write command/data interface. For each burst it picks an eligible channel, computes the mosaic address, issues the command and streams the burst.

## Interface
- BURST_LEN, 16: words per write burst; LINE_PIX must be a multiple of it.
- LINE_PIX, 640: pixels per channel line (quadrant width).
- LINE_NUM, 360: lines per channel frame (quadrant height).
- FRAME_W, 1280: mosaic line stride in words.
- ADDR_W, 20: word address width.
- BASE_ADDR, 0: mosaic frame base address.

Ports:
- clk_ddr  in  1  controller clock; single clock domain.
- rst  in  1  reset, synchronous, active-low.
- ch_vs_pose  in  4  per-channel frame-start pulse, already in the clk_ddr domain.
- ch_level  in  40  packed FIFO fill levels, 10 bits each; ch0 is [9:0].
- ch_rd_data  in  64  packed FIFO show-ahead heads, 16 bits each.
- ch_rd_en  out  4  one-hot FIFO pop.
- wr_cmd_valid  out  1  / wr_cmd_ready  in  1  command handshake.
- wr_cmd_addr  out  ADDR_W  burst start address; wr_cmd_len  out  8  equals BURST_LEN.
- wr_data_valid  out  1  / wr_data_ready  in  1  data handshake.
- wr_data  out  16  / wr_data_last  out  1  burst data and final-beat flag.
- ch_frame_done  out  4  one-cycle pulse when a channel's last frame burst finishes.
- busy  out  1  high in any state other than IDLE or ARB.

## Operation
- Per-channel state:
  - x_cnt: 0..LINE_PIX-BURST_LEN, step BURST_LEN.
  - y_cnt: 0..LINE_NUM.
  - row_base: running line address; no multiplier.
  - done flag.
- Quadrant offsets:
  - ch0: 0.
  - ch1: LINE_PIX.
  - ch2: LINE_NUM*FRAME_W.
  - ch3: LINE_NUM*FRAME_W+LINE_PIX.
- Address = BASE_ADDR + row_base + x_cnt. On frame start, row_base = quadrant offset.
- A channel is eligible when ch_level >= BURST_LEN and its done flag is clear.
- State machine:
  - IDLE to ARB: one cycle after reset release.
  - ARB: round-robin search starting at the channel after the last grant. If any channel is eligible, register the grant and go to CMD; otherwise stay in ARB.
  - CMD: wr_cmd_valid=1 with address and length held stable. On wr_cmd_ready, go to DATA.
  - DATA: wr_data_valid=1. wr_data = ch_rd_data of the granted channel (combinational mux). ch_rd_en[grant] = wr_data_valid & wr_data_ready. A beat counter advances on each accepted beat. wr_data_last=1 on beat BURST_LEN-1. After the last accepted beat, go to DONE.
  - DONE: update the granted channel's counters, then go to ARB.
- Counter update in DONE:
  - x_cnt += BURST_LEN.
  - At line end: x_cnt=0, y_cnt+1, row_base += FRAME_W.
  - When y_cnt reaches LINE_NUM: set done and pulse ch_frame_done.
- Frame-start pulses:
  - ch_vs_pose on a non-granted channel: immediately clears x/y, reloads row_base, clears done.
  - ch_vs_pose on the granted channel (CMD, DATA or DONE): latched as pending and applied in DONE instead of the increment. A burst is never split or re-addressed.
- A channel stays ineligible after done until its next ch_vs_pose, regardless of its level.

## Timing
- Reset (rst=0 at a clk_ddr edge): every output is 0; state=IDLE; all counters, done flags, pending flags and the round-robin pointer are 0, so ch0 has first priority.
- Reset mid-burst aborts immediately; the downstream side must tolerate the truncated burst.
- Cycle cost:
  - Grant is valid the cycle after ARB sees eligibility.
  - wr_cmd_valid rises one cycle after the ARB decision.
  - First data beat is the cycle after command acceptance.
  - Minimum burst period is BURST_LEN+3 cycles: ARB, CMD, data beats, DONE.
- Handshakes:
  - valid is never withdrawn before ready.
  - With ready low, addr, data and last stay stable and no pop occurs.
- ch_level is sampled only in ARB. The FIFO guarantees the popped data stays available during DATA.
- ch_frame_done pulses in the DONE cycle.

## Test plan
- Single burst: ch0 level=16, others 0 -> wr_cmd_addr=0, len=16; 16 pops on ch_rd_en[0]; wr_data_last on beat 16; wr_data matches FIFO order.
- Round robin: all levels=64 -> grants 0,1,2,3,0. First addresses: ch1=640, ch2=460800, ch3=461440.
- Line and frame wrap on ch0:
  - 40th burst at addr 624; 41st at addr 1280.
  - After 14400 bursts, ch_frame_done[0] pulses and ch0 gets no more grants despite level=1023.
- Backpressure: wr_cmd_ready low for 5 cycles -> cmd valid and addr held. wr_data_ready toggling 1/0 -> exactly 16 pops, each coinciding with ready.
- Mid-burst frame start: ch_vs_pose[0] during DATA at addr 1296 -> burst completes at 1296..1311; next ch0 command addr=0. ch_vs_pose[1] at the same time resets ch1 immediately.
- Reset mid-DATA: rst=0 for one cycle -> all outputs 0 next cycle; after release the first grant is ch0 with addr 0.
